// File: rtl/pipe_adder_acc.sv
// pipe_adder_acc: pipelined add / subtract / accumulate unit with a valid/ready handshake.
//
// Operands are combined in stage 0 on the accepting edge. The result then moves through
// LAT register stages; the last stage drives the outputs. A stalled output beat freezes
// the whole pipeline.
//
// Parameters
//   W    operand width; results and the accumulator are W+1 bits wide
//   LAT  number of register stages, legal range 1..4
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operand beat present
//   in_ready   block can accept a beat this cycle (combinational, independent of in_valid)
//   in_a       operand A (unsigned)
//   in_b       operand B (unsigned, ignored by ACC and CLR)
//   in_mode    00 ADD, 01 SUB, 10 ACC, 11 CLR
//   out_valid  result beat present
//   out_ready  consumer accepts the result beat
//   out        W+1 bit result
//   is_odd     out[0]
//   is_zero    out == 0
//   acc_ovf    sticky accumulator wrap flag, travelling with the beat that set it
module pipe_adder_acc #(
  parameter int unsigned W   = 8,
  parameter int unsigned LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [1:0]   in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   out,
  output logic         is_odd,
  output logic         is_zero,
  output logic         acc_ovf
);

  typedef enum logic [1:0] {
    ModeAdd = 2'b00,
    ModeSub = 2'b01,
    ModeAcc = 2'b10,
    ModeClr = 2'b11
  } mode_e;

  logic [LAT-1:0] valid_q;
  logic [W:0]     res_q [LAT];
  logic           ovf_q [LAT];

  logic [W:0]     acc_q;
  logic           acc_ovf_q;

  logic           stall;
  logic           accept;
  logic [W+1:0]   acc_wide;
  logic [W:0]     res_d;
  logic [W:0]     acc_d;
  logic           acc_ovf_d;

  assign stall    = valid_q[LAT-1] & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  // One extra bit so the carry out of bit W is visible.
  assign acc_wide = {1'b0, acc_q} + {2'b00, in_a};

  always_comb begin
    res_d     = '0;
    acc_d     = acc_q;
    acc_ovf_d = acc_ovf_q;
    case (mode_e'(in_mode))
      ModeAdd: res_d = {1'b0, in_a} + {1'b0, in_b};
      ModeSub: res_d = {1'b0, in_a} - {1'b0, in_b};
      ModeAcc: begin
        acc_d = acc_wide[W:0];
        res_d = acc_wide[W:0];
        if (acc_wide[W+1]) acc_ovf_d = 1'b1;
      end
      ModeClr: begin
        acc_d     = '0;
        acc_ovf_d = 1'b0;
        res_d     = '0;
      end
      default: res_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= '0;
      acc_q     <= '0;
      acc_ovf_q <= 1'b0;
      for (int i = 0; i < LAT; i++) begin
        res_q[i] <= '0;
        ovf_q[i] <= 1'b0;
      end
    end else if (!stall) begin
      valid_q[0] <= accept;
      if (accept) begin
        res_q[0]  <= res_d;
        ovf_q[0]  <= acc_ovf_d;
        acc_q     <= acc_d;
        acc_ovf_q <= acc_ovf_d;
      end
      // Data registers only load behind a valid beat, so bubbles leave the last result in place.
      for (int i = 1; i < LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) begin
          res_q[i] <= res_q[i-1];
          ovf_q[i] <= ovf_q[i-1];
        end
      end
    end
  end

  assign out_valid = valid_q[LAT-1];
  assign out       = res_q[LAT-1];
  assign acc_ovf   = ovf_q[LAT-1];
  assign is_odd    = out[0];
  assign is_zero   = (out == '0);

endmodule

// File: tb/tb_pipe_adder_acc.sv
module tb_pipe_adder_acc;

  localparam logic [1:0] MADD = 2'b00;
  localparam logic [1:0] MSUB = 2'b01;
  localparam logic [1:0] MACC = 2'b10;
  localparam logic [1:0] MCLR = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // u1: LAT=1, u2: LAT=2, u3: LAT=3
  logic       v1 = 0, v2 = 0, v3 = 0;
  logic       ir1, ir2, ir3;
  logic [7:0] a1 = 0, a2 = 0, a3 = 0, b1 = 0, b2 = 0, b3 = 0;
  logic [1:0] m1 = 0, m2 = 0, m3 = 0;
  logic       ov1, ov2, ov3;
  logic       or1 = 1, or2 = 1, or3 = 1;
  logic [8:0] o1, o2, o3;
  logic       odd1, odd2, odd3, z1, z2, z3, f1, f2, f3;

  int checks = 0;
  int failures = 0;

  pipe_adder_acc #(.W(8), .LAT(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(ir1), .in_a(a1), .in_b(b1),
    .in_mode(m1), .out_valid(ov1), .out_ready(or1), .out(o1), .is_odd(odd1),
    .is_zero(z1), .acc_ovf(f1)
  );
  pipe_adder_acc #(.W(8), .LAT(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(ir2), .in_a(a2), .in_b(b2),
    .in_mode(m2), .out_valid(ov2), .out_ready(or2), .out(o2), .is_odd(odd2),
    .is_zero(z2), .acc_ovf(f2)
  );
  pipe_adder_acc #(.W(8), .LAT(3)) u3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_ready(ir3), .in_a(a3), .in_b(b3),
    .in_mode(m3), .out_valid(ov3), .out_ready(or3), .out(o3), .is_odd(odd3),
    .is_zero(z3), .acc_ovf(f3)
  );

  // Directed vectors with hand-computed results.
  logic [7:0] add_a [6] = '{8'd0, 8'd1, 8'd5, 8'd2, 8'd3, 8'd1};
  logic [7:0] add_b [6] = '{8'd0, 8'd1, 8'd6, 8'd2, 8'd3, 8'd8};
  logic [8:0] add_o [6] = '{9'd0, 9'd2, 9'd11, 9'd4, 9'd6, 9'd9};
  logic       add_p [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic       add_z [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  logic [1:0] acc_m [5] = '{MCLR, MACC, MACC, MACC, MCLR};
  logic [7:0] acc_a [5] = '{8'd0, 8'd255, 8'd255, 8'd2, 8'd0};
  logic [8:0] acc_o [5] = '{9'd0, 9'd255, 9'h1FE, 9'd0, 9'd0};
  logic       acc_f [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++; if (ov1 !== 1'b0) begin failures++; $display("FAIL rst_ov1 got=%b exp=0", ov1); end
    checks++; if (ov2 !== 1'b0) begin failures++; $display("FAIL rst_ov2 got=%b exp=0", ov2); end
    checks++; if (ov3 !== 1'b0) begin failures++; $display("FAIL rst_ov3 got=%b exp=0", ov3); end
    checks++; if (o2 !== 9'd0) begin failures++; $display("FAIL rst_out got=%h exp=0", o2); end
    checks++; if (z2 !== 1'b1) begin failures++; $display("FAIL rst_zero got=%b exp=1", z2); end
    checks++; if (odd2 !== 1'b0) begin failures++; $display("FAIL rst_odd got=%b exp=0", odd2); end
    checks++; if (f2 !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%b exp=0", f2); end
    checks++; if (ir3 !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", ir3); end
    @(posedge clk);
    #1 rst = 1'b0;
    // out_ready low with no output beat is not a stall; in_ready ignores in_valid.
    or2 = 1'b0;
    #1;
    checks++; if (ir2 !== 1'b1) begin failures++; $display("FAIL idle_ready got=%b exp=1", ir2); end
    or2 = 1'b1;
  endtask

  task automatic test_add_lat1();
    or1 = 1'b1;
    m1  = MADD;
    for (int i = 0; i < 6; i++) begin
      v1 = 1'b1; a1 = add_a[i]; b1 = add_b[i];
      step();
      checks++; if (ov1 !== 1'b1) begin failures++; $display("FAIL add_valid[%0d] got=%b exp=1", i, ov1); end
      checks++; if (o1 !== add_o[i]) begin failures++; $display("FAIL add_out[%0d] got=%0d exp=%0d", i, o1, add_o[i]); end
      checks++; if (odd1 !== add_p[i]) begin failures++; $display("FAIL add_odd[%0d] got=%b exp=%b", i, odd1, add_p[i]); end
      checks++; if (z1 !== add_z[i]) begin failures++; $display("FAIL add_zero[%0d] got=%b exp=%b", i, z1, add_z[i]); end
    end
    v1 = 1'b0;
    step();
    checks++; if (ov1 !== 1'b0) begin failures++; $display("FAIL add_drain got=%b exp=0", ov1); end
  endtask

  task automatic test_lat3();
    or3 = 1'b1;
    v3 = 1'b1; m3 = MADD; a3 = 8'd255; b3 = 8'd255;
    step();
    v3 = 1'b1; m3 = MSUB; a3 = 8'd3; b3 = 8'd5;
    step();
    v3 = 1'b0;
    checks++; if (ov3 !== 1'b0) begin failures++; $display("FAIL lat3_early got=%b exp=0", ov3); end
    step();
    checks++; if (ov3 !== 1'b1) begin failures++; $display("FAIL lat3_add_valid got=%b exp=1", ov3); end
    checks++; if (o3 !== 9'h1FE) begin failures++; $display("FAIL lat3_add got=%h exp=1fe", o3); end
    step();
    checks++; if (ov3 !== 1'b1) begin failures++; $display("FAIL lat3_sub_valid got=%b exp=1", ov3); end
    checks++; if (o3 !== 9'h1FE) begin failures++; $display("FAIL lat3_sub got=%h exp=1fe", o3); end
    step();
    checks++; if (ov3 !== 1'b0) begin failures++; $display("FAIL lat3_drain got=%b exp=0", ov3); end
  endtask

  task automatic test_acc();
    or2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) begin
        v2 = 1'b1; m2 = acc_m[i]; a2 = acc_a[i]; b2 = 8'd99;
      end else begin
        v2 = 1'b0;
      end
      step();
      if (i >= 1) begin
        checks++; if (ov2 !== 1'b1) begin failures++; $display("FAIL acc_valid[%0d] got=%b exp=1", i - 1, ov2); end
        checks++; if (o2 !== acc_o[i-1]) begin failures++; $display("FAIL acc_out[%0d] got=%h exp=%h", i - 1, o2, acc_o[i-1]); end
        checks++; if (f2 !== acc_f[i-1]) begin failures++; $display("FAIL acc_ovf[%0d] got=%b exp=%b", i - 1, f2, acc_f[i-1]); end
      end
    end
    v2 = 1'b0;
    step();
  endtask

  task automatic test_back_pressure();
    int sent = 0;
    int recv = 0;
    logic [8:0] held = '0;
    logic       held_odd = 1'b0;
    m2 = MADD; b2 = 8'd10;
    for (int c = 0; c < 40 && recv < 6; c++) begin
      or2 = !(c >= 3 && c <= 5);
      v2  = (sent < 6);
      a2  = 8'(sent + 1);
      #3;
      if (c >= 3 && c <= 5) begin
        checks++; if (ir2 !== 1'b0) begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=0", c, ir2); end
        checks++; if (ov2 !== 1'b1) begin failures++; $display("FAIL bp_hold_valid[%0d] got=%b exp=1", c, ov2); end
        if (c == 3) begin
          held = o2; held_odd = odd2;
        end else begin
          checks++; if (o2 !== held || odd2 !== held_odd) begin failures++; $display("FAIL bp_hold_out[%0d] got=%h exp=%h", c, o2, held); end
        end
      end
      if (ov2 && or2) begin
        checks++; if (o2 !== 9'(recv + 11)) begin failures++; $display("FAIL bp_out[%0d] got=%0d exp=%0d", recv, o2, recv + 11); end
        checks++; if (odd2 !== 1'(recv + 11)) begin failures++; $display("FAIL bp_odd[%0d] got=%b exp=%b", recv, odd2, 1'(recv + 11)); end
        recv++;
      end
      if (v2 && ir2) sent++;
      @(posedge clk);
      #1;
    end
    v2 = 1'b0; or2 = 1'b1;
    checks++; if (recv != 6) begin failures++; $display("FAIL bp_count got=%0d exp=6", recv); end
    step();
    checks++; if (ov2 !== 1'b0) begin failures++; $display("FAIL bp_extra got=%b exp=0", ov2); end
  endtask

  task automatic test_reset_mid();
    or2 = 1'b1;
    v2 = 1'b1; m2 = MACC; a2 = 8'd5;
    step();
    a2 = 8'd6;
    step();
    checks++; if (ov2 !== 1'b1 || o2 !== 9'd5) begin failures++; $display("FAIL mid_pre got=%b/%0d exp=1/5", ov2, o2); end
    #2 rst = 1'b1;
    #1;
    checks++; if (ov2 !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", ov2); end
    checks++; if (o2 !== 9'd0) begin failures++; $display("FAIL mid_out got=%0d exp=0", o2); end
    v2 = 1'b0;
    #1 rst = 1'b0;
    step();
    checks++; if (ov2 !== 1'b0) begin failures++; $display("FAIL mid_ghost1 got=%b exp=0", ov2); end
    step();
    checks++; if (ov2 !== 1'b0) begin failures++; $display("FAIL mid_ghost2 got=%b exp=0", ov2); end
    v2 = 1'b1; m2 = MACC; a2 = 8'd7;
    step();
    v2 = 1'b0;
    step();
    checks++; if (ov2 !== 1'b1 || o2 !== 9'd7) begin failures++; $display("FAIL mid_acc got=%b/%0d exp=1/7", ov2, o2); end
    step();
  endtask

  task automatic test_bubbles();
    logic exp_v;
    or2 = 1'b1; m2 = MADD; b2 = 8'd1;
    for (int e = 0; e < 8; e++) begin
      v2 = (e < 6) && (e % 2 == 0);
      a2 = 8'(e);
      step();
      exp_v = (e >= 1) && (e - 1 < 6) && ((e - 1) % 2 == 0);
      checks++; if (ov2 !== exp_v) begin failures++; $display("FAIL bub_valid[%0d] got=%b exp=%b", e, ov2, exp_v); end
      if (exp_v) begin
        checks++; if (o2 !== 9'(e)) begin failures++; $display("FAIL bub_out[%0d] got=%0d exp=%0d", e, o2, e); end
      end
    end
    v2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add_lat1();
    test_lat3();
    test_acc();
    test_back_pressure();
    test_reset_mid();
    test_bubbles();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
